// File: rtl/lerp_sched.sv
// Round-robin scheduler sharing one two-stage fixed-point linear interpolator between voices.
// Optional build macro LERP_SCHED_ENDPOINT_EN: ratio MSB set selects the exact end value b.
module lerp_sched #(
  parameter  int NUM_VOICES      = 4,
  parameter  int INPUT_BITS      = 16,
  parameter  int RATIO_FRAC_BITS = 8,
  localparam int VOICE_BITS      = $clog2(NUM_VOICES)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_VOICES-1:0]                      req_valid,
  output logic [NUM_VOICES-1:0]                      req_ready,
  input  logic [NUM_VOICES*INPUT_BITS-1:0]           req_a,
  input  logic [NUM_VOICES*INPUT_BITS-1:0]           req_b,
  input  logic [NUM_VOICES*(RATIO_FRAC_BITS+1)-1:0]  req_ratio,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [INPUT_BITS-1:0]                      out_data,
  output logic [VOICE_BITS-1:0]                      out_voice
);

  localparam int IB = INPUT_BITS;
  localparam int R  = RATIO_FRAC_BITS;
  localparam int RW = RATIO_FRAC_BITS + 1;

  logic [IB-1:0] a_arr [NUM_VOICES];
  logic [IB-1:0] b_arr [NUM_VOICES];
  logic [R-1:0]  f_arr [NUM_VOICES];

  logic                  grant_found;
  logic [VOICE_BITS-1:0] grant_idx;
  logic [VOICE_BITS-1:0] cand;
  logic                  s1_adv, s2_adv, accept;

  logic [VOICE_BITS-1:0] last_q, last_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [IB-1:0]         s1_a_q, s1_b_q;
  logic [R-1:0]          s1_f_q;
  logic [VOICE_BITS-1:0] s1_voice_q;
  logic                  out_valid_q, out_valid_d;
  logic [IB-1:0]         out_data_q;
  logic [VOICE_BITS-1:0] out_voice_q;

  logic signed [IB:0]     diff;
  logic signed [IB+R+1:0] prod;
  logic [IB-1:0]          lerp_res;
  logic [IB-1:0]          result;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      a_arr[i] = req_a[i*IB +: IB];
      b_arr[i] = req_b[i*IB +: IB];
      f_arr[i] = req_ratio[i*RW +: R];
    end
  end

  // Search starts one past the last grant so every voice waits at most NUM_VOICES-1 grants.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_VOICES; i++) begin
      cand = VOICE_BITS'((int'(last_q) + i) % NUM_VOICES);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign s2_adv = !out_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  // Gating with reset keeps a requester from believing it was accepted while state is being cleared.
  assign accept = grant_found && s1_adv && !reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    last_d      = accept ? grant_idx : last_q;
    s1_valid_d  = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
  end

  // Signed difference times unsigned fraction, floored back to sample scale.
  always_comb begin
    diff     = $signed({1'b0, s1_b_q}) - $signed({1'b0, s1_a_q});
    prod     = diff * $signed({1'b0, s1_f_q});
    lerp_res = IB'(prod >>> R) + s1_a_q;
  end

`ifdef LERP_SCHED_ENDPOINT_EN
  logic end_arr [NUM_VOICES];
  logic s1_end_q;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) end_arr[i] = req_ratio[i*RW + R];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       s1_end_q <= 1'b0;
    else if (accept) s1_end_q <= end_arr[grant_idx];
  end

  assign result = s1_end_q ? s1_b_q : lerp_res;
`else
  logic unused_ratio_msbs;

  always_comb begin
    unused_ratio_msbs = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) unused_ratio_msbs = unused_ratio_msbs ^ req_ratio[i*RW + R];
  end

  assign result = lerp_res;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= VOICE_BITS'(NUM_VOICES - 1);
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_f_q      <= '0;
      s1_voice_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_voice_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      last_q      <= last_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        s1_a_q     <= a_arr[grant_idx];
        s1_b_q     <= b_arr[grant_idx];
        s1_f_q     <= f_arr[grant_idx];
        s1_voice_q <= grant_idx;
      end
      if (s2_adv && s1_valid_q) begin
        out_data_q  <= result;
        out_voice_q <= s1_voice_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_voice = out_voice_q;

endmodule

// File: tb/tb_lerp_sched.sv
// Self-checking bench for lerp_sched: directed arithmetic, arbitration, backpressure, reset and
// randomized traffic against a queue-based reference model.
module tb_lerp_sched;

  localparam int NV = 4;
  localparam int IB = 16;
  localparam int R  = 8;
  localparam int RW = R + 1;
  localparam int VB = 2;

  typedef struct {
    int data;
    int voice;
    int avail;
  } item_t;

  logic               clk;
  logic               reset;
  logic [NV-1:0]      req_valid;
  logic [NV-1:0]      req_ready;
  logic [NV*IB-1:0]   req_a;
  logic [NV*IB-1:0]   req_b;
  logic [NV*RW-1:0]   req_ratio;
  logic               out_valid;
  logic               out_ready;
  logic [IB-1:0]      out_data;
  logic [VB-1:0]      out_voice;

  int checks = 0;
  int errors = 0;

  int            va [NV];
  int            vb [NV];
  int            vr [NV];
  logic [NV-1:0] vval;

  lerp_sched #(
    .NUM_VOICES     (NV),
    .INPUT_BITS     (IB),
    .RATIO_FRAC_BITS(R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ratio (req_ratio),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_voice (out_voice)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1);
  end

  // Reference interpolation: a + floor((b-a)*f / 2^R), plus optional exact endpoint.
  function automatic int ref_lerp(int a, int b, int ratio);
    int f, num, q;
`ifdef LERP_SCHED_ENDPOINT_EN
    if (ratio >= (1 << R)) return b;
`endif
    f   = ratio % (1 << R);
    num = (b - a) * f;
    if (num >= 0) q = num / (1 << R);
    else          q = -((-num + (1 << R) - 1) / (1 << R));
    return (a + q) & ((1 << IB) - 1);
  endfunction

  function automatic int ref_winner(logic [NV-1:0] v, int last);
    for (int k = 1; k <= NV; k++) begin
      if (v[(last + k) % NV]) return (last + k) % NV;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NV; i++) begin
      req_a[i*IB +: IB]     = IB'(va[i]);
      req_b[i*IB +: IB]     = IB'(vb[i]);
      req_ratio[i*RW +: RW] = RW'(vr[i]);
    end
    req_valid = vval;
  endtask

  task automatic new_req(input int v);
    va[v]   = int'($urandom_range(0, 65535));
    vb[v]   = int'($urandom_range(0, 65535));
    vr[v]   = int'($urandom_range(0, 511));
    vval[v] = 1'b1;
  endtask

  task automatic apply_reset();
    vval      = '0;
    out_ready = 1'b0;
    drive();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one isolated request and reports accept, latency in cycles and the result seen.
  task automatic send_single(input int v, input int a, input int b, input int r,
                             output bit acc, output int lat, output int data, output int voice);
    @(negedge clk);
    vval      = '0;
    va[v]     = a;
    vb[v]     = b;
    vr[v]     = r;
    vval[v]   = 1'b1;
    out_ready = 1'b0;
    drive();
    #1;
    acc = req_ready[v];
    @(posedge clk);
    #1;
    vval[v] = 1'b0;
    drive();
    lat   = -1;
    data  = -1;
    voice = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat   = k;
        data  = int'(out_data);
        voice = int'(out_voice);
        break;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int v = 0; v < NV; v++) new_req(v);
    out_ready = 1'b1;
    drive();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
    checks++;
    if (out_voice !== '0) begin errors++; $display("FAIL reset_out_voice got %0d exp 0", out_voice); end
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    apply_reset();
  endtask

  task automatic test_arith();
    int  ta [4] = '{0, 256, 10, 0};
    int  tb [4] = '{256, 0, 0, 65535};
    int  tr [4] = '{128, 128, 1, 255};
    int  te [4] = '{128, 128, 9, 65279};
    bit  acc;
    int  lat, data, voice;
    for (int i = 0; i < 4; i++) begin
      send_single(0, ta[i], tb[i], tr[i], acc, lat, data, voice);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL arith%0d_accept got %b exp 1", i, acc); end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL arith%0d_latency got %0d exp 2", i, lat); end
      checks++;
      if (data != te[i]) begin errors++; $display("FAIL arith%0d_data got %0d exp %0d", i, data, te[i]); end
      checks++;
      if (voice != 0) begin errors++; $display("FAIL arith%0d_voice got %0d exp 0", i, voice); end
    end
  endtask

  task automatic test_endpoint();
    bit acc;
    int lat, data, voice, exp1, exp2;
`ifdef LERP_SCHED_ENDPOINT_EN
    exp1 = 200;
    exp2 = 1000;
`else
    exp1 = 100;
    exp2 = 996;
`endif
    send_single(2, 100, 200, 'h100, acc, lat, data, voice);
    checks++;
    if (data != exp1) begin errors++; $display("FAIL endpoint_1p0 got %0d exp %0d", data, exp1); end
    checks++;
    if (voice != 2 || lat != 2) begin
      errors++; $display("FAIL endpoint_voice_lat got v%0d/l%0d exp v2/l2", voice, lat);
    end
    send_single(1, 0, 1000, 'h1FF, acc, lat, data, voice);
    checks++;
    if (data != exp2) begin errors++; $display("FAIL endpoint_1ff got %0d exp %0d", data, exp2); end
  endtask

  task automatic test_round_robin();
    item_t        q[$];
    item_t        it;
    logic [NV-1:0] exp_rdy;
    int           g;
    apply_reset();
    out_ready = 1'b1;
    for (int v = 0; v < NV; v++) new_req(v);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive();
      #1;
      g       = k % NV;
      exp_rdy = NV'(1) << g;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (k >= 2)) begin
        errors++; $display("FAIL rr_out_valid k=%0d got %b exp %b", k, out_valid, k >= 2);
      end
      if (k >= 2) begin
        it = q.pop_front();
        checks++;
        if (out_voice !== VB'(it.voice) || out_data !== IB'(it.data)) begin
          errors++;
          $display("FAIL rr_result k=%0d got v%0d/%0d exp v%0d/%0d", k, out_voice, out_data, it.voice, it.data);
        end
      end
      q.push_back('{ref_lerp(va[g], vb[g], vr[g]), g, 0});
      new_req(g);
    end
  endtask

  task automatic test_backpressure();
    logic [NV-1:0] t_rdy [11] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    bit            t_or  [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1};
    int            t_v   [11] = '{-1, -1, 0, 0, 0, 0, 1, 1, 2, 3, -1};
    int            e [NV];
    apply_reset();
    for (int v = 0; v < NV; v++) begin
      new_req(v);
      e[v] = ref_lerp(va[v], vb[v], vr[v]);
    end
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      out_ready = t_or[k];
      drive();
      #1;
      checks++;
      if (req_ready !== t_rdy[k]) begin
        errors++; $display("FAIL bp_ready k=%0d got %b exp %b", k, req_ready, t_rdy[k]);
      end
      checks++;
      if (out_valid !== (t_v[k] >= 0)) begin
        errors++; $display("FAIL bp_out_valid k=%0d got %b exp %b", k, out_valid, t_v[k] >= 0);
      end
      if (t_v[k] >= 0) begin
        checks++;
        if (out_voice !== VB'(t_v[k]) || out_data !== IB'(e[t_v[k]])) begin
          errors++;
          $display("FAIL bp_result k=%0d got v%0d/%0d exp v%0d/%0d", k, out_voice, out_data, t_v[k], e[t_v[k]]);
        end
      end
      for (int v = 0; v < NV; v++) if (t_rdy[k][v]) vval[v] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [NV-1:0] t_rdy [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    int            e [NV];
    int            ev;
    apply_reset();
    for (int v = 0; v < NV; v++) new_req(v);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive();
      #1;
      vval[k] = 1'b0;
    end
    @(negedge clk);
    drive();
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_inflight got %b exp 1", out_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_drop got %b exp 0", out_valid); end
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL rm_ready_in_reset got %b exp 0000", req_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    new_req(0);
    new_req(1);
    for (int v = 0; v < NV; v++) e[v] = ref_lerp(va[v], vb[v], vr[v]);
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      drive();
      #1;
      checks++;
      if (req_ready !== t_rdy[j]) begin
        errors++; $display("FAIL rm_ready j=%0d got %b exp %b", j, req_ready, t_rdy[j]);
      end
      checks++;
      if (out_valid !== (j >= 2)) begin
        errors++; $display("FAIL rm_out_valid j=%0d got %b exp %b", j, out_valid, j >= 2);
      end
      if (j >= 2) begin
        ev = j - 2;
        checks++;
        if (out_voice !== VB'(ev) || out_data !== IB'(e[ev])) begin
          errors++;
          $display("FAIL rm_result j=%0d got v%0d/%0d exp v%0d/%0d", j, out_voice, out_data, ev, e[ev]);
        end
      end
      for (int v = 0; v < NV; v++) if (t_rdy[j][v]) vval[v] = 1'b0;
    end
  endtask

  task automatic test_random();
    item_t         q[$];
    logic [NV-1:0] exp_rdy;
    int            last_m, w, cyc;
    bit            acc, exp_ov;
    apply_reset();
    last_m = NV - 1;
    cyc    = 0;
    for (int v = 0; v < NV; v++) if ($urandom_range(0, 1) == 1) new_req(v);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 65);
      drive();
      #1;
      w       = ref_winner(vval, last_m);
      acc     = (w >= 0) && (q.size() < 2 || out_ready);
      exp_rdy = acc ? (NV'(1) << w) : '0;
      exp_ov  = (q.size() > 0) && (q[0].avail <= cyc);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, req_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== exp_ov) begin
        errors++; $display("FAIL rnd_out_valid n=%0d got %b exp %b", n, out_valid, exp_ov);
      end
      if (exp_ov) begin
        checks++;
        if (out_voice !== VB'(q[0].voice) || out_data !== IB'(q[0].data)) begin
          errors++;
          $display("FAIL rnd_result n=%0d got v%0d/%0d exp v%0d/%0d", n, out_voice, out_data, q[0].voice, q[0].data);
        end
      end
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].avail < cyc + 1) q[0].avail = cyc + 1;
      end
      if (acc) begin
        q.push_back('{ref_lerp(va[w], vb[w], vr[w]), w, cyc + 2});
        last_m  = w;
        vval[w] = 1'b0;
      end
      for (int v = 0; v < NV; v++) if (!vval[v] && $urandom_range(0, 99) < 50) new_req(v);
      cyc++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    vval      = '0;
    for (int v = 0; v < NV; v++) begin
      va[v] = 0;
      vb[v] = 0;
      vr[v] = 0;
    end
    drive();
    test_reset();
    test_arith();
    test_endpoint();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
